// File: rtl/seven_seg_scan_pkg.sv
// seven_seg_scan_pkg: segment bit order, hex segment patterns and blank pattern
// Segment vectors are {g,f,e,d,c,b,a}; bit 0 = segment a; active-high internally.
package seven_seg_scan_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Index n holds the pattern for hex digit n.
    localparam seg_t [15:0] SEG_PAT = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: bus between register logic (master) and the display scanner (slave)
// master drives load/value/dp_in/digit_en/blank_lz; slave drives seg_out/dp_out/an_out/frame_done.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);

    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;

    modport master (
        output load, value, dp_in, digit_en, blank_lz,
        input  seg_out, dp_out, an_out, frame_done
    );

    modport slave (
        input  load, value, dp_in, digit_en, blank_lz,
        output seg_out, dp_out, an_out, frame_done
    );

endinterface

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational hex nibble to active-high {g..a} segment pattern
// Ports: nib (4-bit hex digit in), seg (7-bit active-high segments out).
module seven_seg_decode
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = SEG_PAT[nib];

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit seven-segment scanner with load register and blanking
// Ports: clk, reset (sync, active-high), bus (slave side of seven_seg_scan_if):
//   load/value/dp_in/digit_en/blank_lz in; seg_out/dp_out/an_out/frame_done out (registered).
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit AN_ACTIVE_LOW  = 1
) (
    input logic         clk,
    input logic         reset,
    seven_seg_scan_if.slave bus
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    // XOR masks: all-ones inverts to active-low, zero leaves active-high.
    localparam seg_t                  SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] hold_val;
    logic [NUM_DIGITS-1:0]   hold_dp;
    logic [NUM_DIGITS-1:0]   hold_en;
    logic                    hold_lz;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;

    logic [3:0]            nib;
    seg_t                  dec_seg;
    seg_t                  seg_act;
    logic                  dp_act;
    logic [NUM_DIGITS-1:0] an_act;
    logic                  blanking;
    logic                  lz_dark;

    seven_seg_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        nib      = hold_val[{idx, 2'b00} +: 4];
        blanking = cnt < BLANK_END;
        // Zero-blank only when this nibble and every higher one are zero.
        lz_dark  = hold_lz && (idx != '0) && ((hold_val >> {idx, 2'b00}) == '0);
        seg_act  = (blanking || !hold_en[idx] || lz_dark) ? SEG_BLANK : dec_seg;
        // A zero-blanked digit still shows its decimal point; a disabled one does not.
        dp_act   = !blanking && hold_en[idx] && hold_dp[idx];
        an_act   = blanking ? '0 : NUM_DIGITS'(1) << idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_val       <= '0;
            hold_dp        <= '0;
            hold_en        <= '0;
            hold_lz        <= 1'b0;
            cnt            <= '0;
            idx            <= '0;
            bus.seg_out    <= SEG_BLANK ^ SEG_POL;
            bus.dp_out     <= SEG_ACTIVE_LOW;
            bus.an_out     <= AN_POL;
            bus.frame_done <= 1'b0;
        end else begin
            if (bus.load) begin
                hold_val <= bus.value;
                hold_dp  <= bus.dp_in;
                hold_en  <= bus.digit_en;
                hold_lz  <= bus.blank_lz;
            end
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_LAST)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            bus.frame_done <= (cnt == CNT_LAST) && (idx == IDX_LAST);
            bus.seg_out    <= seg_act ^ SEG_POL;
            bus.dp_out     <= dp_act ^ SEG_ACTIVE_LOW;
            bus.an_out     <= an_act ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed bench for seven_seg_scan (4 digits, 4-cycle slots, 1 blank cycle)
// dut_l uses active-low pins, dut_h active-high; both see identical inputs.
module tb_seven_seg_scan;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(4)) bl ();
    seven_seg_scan_if #(.NUM_DIGITS(4)) bh ();

    assign bh.load     = bl.load;
    assign bh.value    = bl.value;
    assign bh.dp_in    = bl.dp_in;
    assign bh.digit_en = bl.digit_en;
    assign bh.blank_lz = bl.blank_lz;

    seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bl)
    );

    seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (bh)
    );

    // Resets, then loads on the first non-reset edge; returns at the negedge after it (k=1).
    task automatic start(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                         input logic lz);
        @(negedge clk);
        reset = 1'b1;
        bl.load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bl.load = 1'b1;
        bl.value = v;
        bl.dp_in = dp;
        bl.digit_en = en;
        bl.blank_lz = lz;
        @(negedge clk);
        bl.load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bl.load = 1'b1;
        bl.value = 16'hFFFF;
        bl.digit_en = 4'hF;
        repeat (3) @(negedge clk);
        bl.load = 1'b0;
        n_tests++; if (bl.an_out !== 4'b1111) begin n_fail++; $display("FAIL reset_an_l got %b want 1111", bl.an_out); end
        n_tests++; if (bl.seg_out !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg_l got %b want 1111111", bl.seg_out); end
        n_tests++; if (bl.dp_out !== 1'b1) begin n_fail++; $display("FAIL reset_dp_l got %b want 1", bl.dp_out); end
        n_tests++; if (bl.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd_l got %b want 0", bl.frame_done); end
        n_tests++; if (bh.an_out !== 4'b0000) begin n_fail++; $display("FAIL reset_an_h got %b want 0000", bh.an_out); end
        n_tests++; if (bh.seg_out !== 7'b0000000) begin n_fail++; $display("FAIL reset_seg_h got %b want 0000000", bh.seg_out); end
        n_tests++; if (bh.dp_out !== 1'b0) begin n_fail++; $display("FAIL reset_dp_h got %b want 0", bh.dp_out); end
        n_tests++; if (bh.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd_h got %b want 0", bh.frame_done); end
    endtask

    // Value 12AF over two frames: F, A, 2, 1 on digits 0..3, active-low and active-high.
    task automatic test_scan_order();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        logic [6:0] exp_sg;
        int s, d, frames;
        exp_seg = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        frames = 0;
        start(16'h12AF, 4'h0, 4'hF, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) @(negedge clk);
            s = (k - 1) % 4;
            d = ((k - 1) / 4) % 4;
            exp_an = (s == 0) ? 4'b1111 : 4'b1111 ^ (4'b0001 << d);
            exp_sg = (s == 0) ? 7'b1111111 : exp_seg[d];
            frames += int'(bl.frame_done);
            n_tests++; if (bl.an_out !== exp_an) begin n_fail++; $display("FAIL scan_an_l k=%0d got %b want %b", k, bl.an_out, exp_an); end
            n_tests++; if (bl.seg_out !== exp_sg) begin n_fail++; $display("FAIL scan_seg_l k=%0d got %b want %b", k, bl.seg_out, exp_sg); end
            n_tests++; if (bl.dp_out !== 1'b1) begin n_fail++; $display("FAIL scan_dp_l k=%0d got %b want 1", k, bl.dp_out); end
            n_tests++; if (bh.an_out !== ~exp_an) begin n_fail++; $display("FAIL scan_an_h k=%0d got %b want %b", k, bh.an_out, ~exp_an); end
            n_tests++; if (bh.seg_out !== ~exp_sg) begin n_fail++; $display("FAIL scan_seg_h k=%0d got %b want %b", k, bh.seg_out, ~exp_sg); end
            n_tests++; if (bl.frame_done !== (k % 16 == 0)) begin n_fail++; $display("FAIL scan_fd k=%0d got %b want %b", k, bl.frame_done, k % 16 == 0); end
        end
        n_tests++; if (frames != 2) begin n_fail++; $display("FAIL scan_frames got %0d want 2", frames); end
    endtask

    // Case 0: 0040 blank_lz, dp on blanked digit 2. Case 1: 0000 blank_lz.
    // Case 2: 8888 digit_en=0101 dp_in=0011 (disabled digit 1 keeps dp dark).
    task automatic test_lz_mask();
        logic [15:0] vals [3];
        logic [3:0]  dps [3];
        logic [3:0]  ens [3];
        logic        lzs [3];
        logic [6:0]  exp_seg [3][4];
        logic [3:0]  exp_dp [3];
        logic [3:0]  exp_an;
        logic [6:0]  exp_sg;
        logic        exp_d;
        int s, d;
        vals = '{16'h0040, 16'h0000, 16'h8888};
        dps  = '{4'b0100, 4'b0000, 4'b0011};
        ens  = '{4'b1111, 4'b1111, 4'b0101};
        lzs  = '{1'b1, 1'b1, 1'b0};
        exp_seg[0] = '{7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111};
        exp_seg[1] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        exp_seg[2] = '{7'b0000000, 7'b1111111, 7'b0000000, 7'b1111111};
        exp_dp = '{4'b1011, 4'b1111, 4'b1110};
        for (int c = 0; c < 3; c++) begin
            start(vals[c], dps[c], ens[c], lzs[c]);
            for (int k = 1; k <= 16; k++) begin
                if (k > 1) @(negedge clk);
                s = (k - 1) % 4;
                d = ((k - 1) / 4) % 4;
                exp_an = (s == 0) ? 4'b1111 : 4'b1111 ^ (4'b0001 << d);
                exp_sg = (s == 0) ? 7'b1111111 : exp_seg[c][d];
                exp_d  = (s == 0) ? 1'b1 : exp_dp[c][d];
                n_tests++; if (bl.an_out !== exp_an) begin n_fail++; $display("FAIL lzmask_an c=%0d k=%0d got %b want %b", c, k, bl.an_out, exp_an); end
                n_tests++; if (bl.seg_out !== exp_sg) begin n_fail++; $display("FAIL lzmask_seg c=%0d k=%0d got %b want %b", c, k, bl.seg_out, exp_sg); end
                n_tests++; if (bl.dp_out !== exp_d) begin n_fail++; $display("FAIL lzmask_dp c=%0d k=%0d got %b want %b", c, k, bl.dp_out, exp_d); end
            end
        end
    endtask

    task automatic test_mid_load();
        start(16'h0003, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        n_tests++; if (bl.seg_out !== 7'b0110000) begin n_fail++; $display("FAIL midload_pre got %b want 0110000", bl.seg_out); end
        bl.load = 1'b1;
        bl.value = 16'h0007;
        @(negedge clk);
        bl.load = 1'b0;
        n_tests++; if (bl.seg_out !== 7'b0110000) begin n_fail++; $display("FAIL midload_edge1 got %b want 0110000", bl.seg_out); end
        n_tests++; if (bl.an_out !== 4'b1110) begin n_fail++; $display("FAIL midload_an1 got %b want 1110", bl.an_out); end
        @(negedge clk);
        n_tests++; if (bl.seg_out !== 7'b1111000) begin n_fail++; $display("FAIL midload_edge2 got %b want 1111000", bl.seg_out); end
        n_tests++; if (bl.an_out !== 4'b1110) begin n_fail++; $display("FAIL midload_an2 got %b want 1110", bl.an_out); end
        @(negedge clk);
        n_tests++; if (bl.an_out !== 4'b1111) begin n_fail++; $display("FAIL midload_gap got %b want 1111", bl.an_out); end
        @(negedge clk);
        n_tests++; if (bl.an_out !== 4'b1101) begin n_fail++; $display("FAIL midload_next got %b want 1101", bl.an_out); end
        n_tests++; if (bl.seg_out !== 7'b1000000) begin n_fail++; $display("FAIL midload_next_seg got %b want 1000000", bl.seg_out); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_an [6];
        exp_an = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
        start(16'h12AF, 4'h0, 4'hF, 1'b0);
        repeat (9) @(negedge clk);
        n_tests++; if (bl.an_out !== 4'b1011) begin n_fail++; $display("FAIL rstmid_pre got %b want 1011", bl.an_out); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if (bl.an_out !== 4'b1111) begin n_fail++; $display("FAIL rstmid_an_l got %b want 1111", bl.an_out); end
        n_tests++; if (bl.seg_out !== 7'b1111111) begin n_fail++; $display("FAIL rstmid_seg_l got %b want 1111111", bl.seg_out); end
        n_tests++; if (bl.dp_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_dp_l got %b want 1", bl.dp_out); end
        n_tests++; if (bh.an_out !== 4'b0000) begin n_fail++; $display("FAIL rstmid_an_h got %b want 0000", bh.an_out); end
        n_tests++; if (bh.seg_out !== 7'b0000000) begin n_fail++; $display("FAIL rstmid_seg_h got %b want 0000000", bh.seg_out); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++; if (bl.an_out !== exp_an[k]) begin n_fail++; $display("FAIL rstmid_restart k=%0d got %b want %b", k + 1, bl.an_out, exp_an[k]); end
            n_tests++; if (bl.seg_out !== 7'b1111111) begin n_fail++; $display("FAIL rstmid_dark k=%0d got %b want 1111111", k + 1, bl.seg_out); end
        end
    endtask

    initial begin
        bl.load = 1'b0;
        bl.value = '0;
        bl.dp_in = '0;
        bl.digit_en = '0;
        bl.blank_lz = 1'b0;
        test_reset();
        test_scan_order();
        test_lz_mask();
        test_mid_load();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
